// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/PC stage: run state, default geometry,
// PC constants and execute opcode encodings used by benches.
package wb_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } wb_state_e;

  localparam int          NREG_DEF     = 32;
  localparam int          ADDR_W_DEF   = $clog2(NREG_DEF);
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_STEP_DEF  = 4;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_U = 7'b0110111;
  localparam logic [6:0] OP_B = 7'b1100011;

endpackage

// File: rtl/wb_regfile.sv
// Architectural register file: two async read ports, one sync write port,
// register 0 hardwired to zero. Write-through forwarding under WB_PC_UNIT_BYPASS_EN.
module wb_regfile
  import wb_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [31:0]             wr_data,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  output logic [31:0]             rs1_data,
  output logic [31:0]             rs2_data
);

  localparam int AW = $clog2(NREG);

  logic [31:0] mem [1:NREG-1];

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  function automatic logic [31:0] stored(input logic [AW-1:0] a);
    return addr_ok(a) ? mem[a] : 32'h0;
  endfunction

  logic wr_hit;
  assign wr_hit = wr_en && addr_ok(wr_addr);

  // NOTE: the array is cleared by the async reset, so it must stay in flops
  // rather than a RAM macro; a RAM-backed version would need a clear sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef WB_PC_UNIT_BYPASS_EN
  assign rs1_data = (wr_hit && rs1_addr == wr_addr) ? wr_data : stored(rs1_addr);
  assign rs2_data = (wr_hit && rs2_addr == wr_addr) ? wr_data : stored(rs2_addr);
`else
  assign rs1_data = stored(rs1_addr);
  assign rs2_data = stored(rs2_addr);
`endif

endmodule

// File: rtl/wb_pc_unit.sv
// Writeback/PC stage: retires execute results into the register file and PC,
// halting on execute errors. Optional forwarding via WB_PC_UNIT_BYPASS_EN.
module wb_pc_unit
  import wb_pkg::*;
#(
  parameter int          NREG     = NREG_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          PC_STEP  = PC_STEP_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  input  logic [$clog2(NREG)-1:0] rd_addr,
  input  logic [31:0]             sonuc,
  input  logic                    we,
  input  logic                    pc_update,
  input  logic                    hata,
  input  logic                    clear_halt,
  output logic [31:0]             rs1_data,
  output logic [31:0]             rs2_data,
  output logic [31:0]             pc,
  output logic                    halted,
  output logic [31:0]             err_pc,
  output logic [31:0]             retire_cnt
);

  wb_state_e state_q, state_d;
  logic      accept, err, retire, leave_halt;

  assign ready_o    = (state_q == RUN);
  assign halted     = (state_q == HALT);
  assign accept     = valid_i && ready_o;
  // A taken branch that also writes is an illegal combination from execute.
  assign err        = hata || (we && pc_update);
  assign retire     = accept && !err;
  assign leave_halt = halted && clear_halt;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (accept && err) state_d = HALT;
      HALT: if (clear_halt)    state_d = RUN;
      default:                 state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc         <= RESET_PC;
      err_pc     <= '0;
      retire_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        pc         <= pc + (pc_update ? sonuc : 32'(PC_STEP));
        retire_cnt <= retire_cnt + 32'd1;
      end else if (accept) begin
        err_pc <= pc;
      end else if (leave_halt) begin
        pc <= RESET_PC;
      end
    end
  end

  wb_regfile #(.NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (retire && we),
    .wr_addr  (rd_addr),
    .wr_data  (sonuc),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

endmodule

// File: tb/tb_wb_pc_unit.sv
// Scoreboard bench for wb_pc_unit: stimulus pushes the expected stage state for
// each cycle, a negedge monitor pops and compares it against the DUT outputs.
module tb_wb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, we, pc_update, hata, clear_halt;
  logic        ready_o, halted;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] sonuc, rs1_data, rs2_data, pc, err_pc, retire_cnt;

  always #5 clk = ~clk;

  wb_pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .sonuc      (sonuc),
    .we         (we),
    .pc_update  (pc_update),
    .hata       (hata),
    .clear_halt (clear_halt),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .pc         (pc),
    .halted     (halted),
    .err_pc     (err_pc),
    .retire_cnt (retire_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] err_pc;
    logic [31:0] retire;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

`ifdef WB_PC_UNIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got %08h expected %08h", name, field, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic w, input logic pu, input logic h,
                     input logic clr, input logic [4:0] rd, input logic [31:0] s,
                     input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    valid_i = v; we = w; pc_update = pu; hata = h; clear_halt = clr;
    rd_addr = rd; sonuc = s; rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic expect_state(input string name, input logic [31:0] p,
                              input logic h, input logic [31:0] ep,
                              input logic [31:0] rc, input logic [31:0] d1,
                              input logic [31:0] d2);
    exp_t x;
    x.name = name; x.pc = p; x.halted = h; x.err_pc = ep;
    x.retire = rc; x.rs1 = d1; x.rs2 = d2;
    q.push_back(x);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, "pc",         pc,                 e.pc);
        check(e.name, "halted",     {31'h0, halted},    {31'h0, e.halted});
        check(e.name, "ready_o",    {31'h0, ready_o},   {31'h0, ~e.halted});
        check(e.name, "err_pc",     err_pc,             e.err_pc);
        check(e.name, "retire_cnt", retire_cnt,         e.retire);
        check(e.name, "rs1_data",   rs1_data,           e.rs1);
        check(e.name, "rs2_data",   rs2_data,           e.rs2);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    valid_i = 0; we = 0; pc_update = 0; hata = 0; clear_halt = 0;
    rd_addr = 0; sonuc = 0; rs1_addr = 0; rs2_addr = 0;
    #1;
    expect_state("reset", 32'h0, 0, 32'h0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    //  v  we pu ha clr rd  sonuc          rs1 rs2
    cyc(1, 1, 0, 0, 0, 5, 32'h0000_00AA, 5, 0);
    expect_state("wr5_same", 32'h0, 0, 0, 0, BYP ? 32'hAA : 32'h0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 0);
    expect_state("wr5_next", 32'h4, 0, 0, 1, 32'hAA, 0);
    cyc(1, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 5);
    expect_state("wr0_same", 32'h4, 0, 0, 1, 0, 32'hAA);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5);
    expect_state("wr0_next", 32'h8, 0, 0, 2, 0, 32'hAA);
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 0);
    expect_state("plain_a", 32'h8, 0, 0, 2, 32'hAA, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 0);
    expect_state("plain_b", 32'hC, 0, 0, 3, 32'hAA, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 5, 0);
    expect_state("br_back_in", 32'h10, 0, 0, 4, 32'hAA, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'hFFFF_FFF4, 5, 0);
    expect_state("br_back_out", 32'h08, 0, 0, 5, 32'hAA, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 0);
    expect_state("pc_top", 32'hFFFF_FFFC, 0, 0, 6, 32'hAA, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'h20, 5, 0);
    expect_state("pc_wrap", 32'h0, 0, 0, 7, 32'hAA, 0);
    cyc(1, 1, 0, 1, 0, 5, 32'h55, 5, 0);
    expect_state("hata_in", 32'h20, 0, 0, 8, 32'hAA, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 0);
    expect_state("halt_nowr", 32'h20, 1, 32'h20, 8, 32'hAA, 0);
    cyc(1, 1, 0, 0, 0, 6, 32'h66, 6, 0);
    expect_state("halt_ign", 32'h20, 1, 32'h20, 8, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 6, 0);
    expect_state("clr_in", 32'h20, 1, 32'h20, 8, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 6);
    expect_state("clr_out", 32'h0, 0, 32'h20, 8, 32'hAA, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 5, 6);
    expect_state("clr_run", 32'h0, 0, 32'h20, 8, 32'hAA, 0);
    cyc(1, 1, 1, 0, 0, 7, 32'h77, 7, 0);
    expect_state("wepu_in", 32'h4, 0, 32'h20, 9, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 7, 0);
    expect_state("wepu_halt", 32'h4, 1, 32'h4, 9, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 7, 0);
    expect_state("wepu_clr", 32'h4, 1, 32'h4, 9, 0, 0);
    cyc(1, 1, 0, 0, 0, 3, 32'h33, 0, 3);
    expect_state("wr3_old", 32'h0, 0, 32'h4, 9, 0, BYP ? 32'h33 : 32'h0);
    cyc(1, 1, 0, 0, 0, 3, 32'h7, 3, 3);
    expect_state("byp_same", 32'h4, 0, 32'h4, 10,
                 BYP ? 32'h7 : 32'h33, BYP ? 32'h7 : 32'h33);
    cyc(0, 0, 0, 0, 0, 0, 0, 3, 3);
    expect_state("byp_next", 32'h8, 0, 32'h4, 11, 32'h7, 32'h7);
    cyc(1, 0, 0, 1, 1, 0, 0, 3, 0);
    expect_state("err_clr_in", 32'h8, 0, 32'h4, 11, 32'h7, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 3, 0);
    expect_state("err_wins", 32'h8, 1, 32'h8, 11, 32'h7, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b0; rs1_addr = 5; rs2_addr = 3;
    expect_state("async_rst", 32'h0, 0, 32'h0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("drain", "queue_left", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/wb_pc_unit.md
Name: wb_pc_unit

Overview:
- Writeback/PC stage directly downstream of the combinational execute (ALU/branch) stage.
- Holds the architectural register file and the program counter.
- Drives rs1_data/rs2_data into the execute stage, and consumes its sonuc/we/pc_update/hata results.
- A RUN/HALT state machine stops retirement on an error and counts retired instructions.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- RESET_PC, 32'h0000_0000, PC value after reset and after clear_halt.
- PC_STEP, 4, PC increment for non-branching or not-taken instructions.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  execute result present this cycle.
- ready_o  out  1  stage accepts a result (1 only in RUN).
- rs1_addr  in  $clog2(NREG)  read address A.
- rs2_addr  in  $clog2(NREG)  read address B.
- rd_addr  in  $clog2(NREG)  destination register of the retiring instruction.
- sonuc  in  32  execute result: rd data, or signed branch offset.
- we  in  1  register write request.
- pc_update  in  1  branch taken.
- hata  in  1  execute error.
- clear_halt  in  1  leave HALT (single-cycle pulse).
- rs1_data  out  32  combinational read A.
- rs2_data  out  32  combinational read B.
- pc  out  32  current PC.
- halted  out  1  state==HALT.
- err_pc  out  32  PC of the instruction that caused the halt.
- retire_cnt  out  32  instructions retired since reset.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; all registers=0; state=RUN.
  - err_pc=0; retire_cnt=0; halted=0; ready_o=1.
  - Deassertion takes effect on the next rising clk.
- Accept: an accept occurs when valid_i & ready_o at a rising clk. With no accept, pc, registers and counters hold.
- Error condition: hata=1, or (we=1 & pc_update=1). On an accepted error:
  - No register write; pc unchanged.
  - err_pc<=pc; state<=HALT; retire_cnt unchanged.
- Normal accept:
  - If we=1 and rd_addr!=0: reg[rd_addr]<=sonuc. Writes to register 0 are discarded.
  - If pc_update=1: pc<=pc+sonuc (two's complement, modulo 2^32, wraps silently).
  - Otherwise: pc<=pc+PC_STEP (wraps at 2^32).
  - retire_cnt<=retire_cnt+1 (wraps 32'hFFFF_FFFF->0).
- Write latency: a register write is visible on rs*_data in the cycle after the accept (no bypass unless the feature below is enabled).
- Reads: reading address 0 always returns 0. Out-of-range addresses (>=NREG) return 0.
- HALT state:
  - ready_o=0, so valid_i is ignored.
  - Read ports stay functional.
  - clear_halt=1 at a clk edge: state<=RUN, pc<=RESET_PC. Registers, err_pc and retire_cnt are kept.
- clear_halt in RUN has no effect. If clear_halt and an accepted error coincide, the error wins and the state goes to HALT.
- State transitions:
  - RUN -(accepted error)-> HALT.
  - HALT -(clear_halt)-> RUN.
  - Any state -(rst_n=0)-> RUN.

Optional Feature:
- Macro: WB_PC_UNIT_BYPASS_EN.
- When defined: write-through forwarding. If a normal accept with we=1 and rd_addr!=0 occurs this cycle and rs1_addr (or rs2_addr) == rd_addr, then rs1_data (rs2_data) = sonuc combinationally. Address 0 is never forwarded.
- When undefined: reads return only the stored array value, so the new value appears one cycle later.

Decomposition:
- Shared package wb_pkg:
  - state enum {RUN, HALT}.
  - NREG default and address-width constant.
  - RESET_PC and PC_STEP defaults.
  - Execute opcode constants (R/I/U/B) for benches.
- One sub-module: wb_regfile.
  - Two asynchronous read ports, one synchronous write port, async reset clear, hardwired-zero register 0.
  - The bypass ifdef lives in wb_regfile.

Test Plan:
- Reset, then accept we=1, rd=5, sonuc=32'h0000_00AA. Next cycle: rs1_addr=5 -> rs1_data=32'hAA, pc=4, retire_cnt=1.
- Accept we=1, rd=0, sonuc=32'hFFFF_FFFF. Then rs1_addr=0 -> rs1_data=0, pc advances by 4.
- pc=32'h10, accept pc_update=1, sonuc=32'hFFFF_FFF8 -> pc=32'h08. Then pc=32'hFFFF_FFFC with plain accept -> pc=0 (wrap).
- pc=32'h20, accept hata=1 -> halted=1, err_pc=32'h20, ready_o=0. A later valid_i with we=1 writes nothing. clear_halt -> pc=RESET_PC, halted=0, registers preserved.
- Accept we=1 & pc_update=1 -> treated as an error: HALT, no write, pc frozen.
- Bypass build: accept we=1, rd=3, sonuc=7 with rs2_addr=3 -> rs2_data=7 in the same cycle. Non-bypass build: old value in the same cycle, 7 in the next cycle.
